wb_sequencer: RTL and testbench



---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_retire_counter.sv | 18 +
 rtl/wb_sequencer.sv | 111 +++++++++++
 tb/tb_wb_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the execute/memory/write-back sequencer.
// Instruction classes, FSM states and MemtoReg polarity.
package wb_pkg;

    localparam logic [1:0] ICLASS_RTYPE = 2'b00;
    localparam logic [1:0] ICLASS_LOAD  = 2'b01;
    localparam logic [1:0] ICLASS_STORE = 2'b10;
    localparam logic [1:0] ICLASS_NOP   = 2'b11;

    localparam logic MEMTOREG_DM  = 1'b0;
    localparam logic MEMTOREG_ALU = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_MEM  = 3'd2,
        ST_WB   = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    function automatic logic is_mem(input logic [1:0] c);
        return (c == ICLASS_LOAD) || (c == ICLASS_STORE);
    endfunction

    function automatic logic writes_reg(input logic [1:0] c);
        return (c == ICLASS_RTYPE) || (c == ICLASS_LOAD);
    endfunction

endpackage

// File: rtl/wb_retire_counter.sv
// Free-running count of retired instructions (done pulses).
// Only instantiated when WBSEQ_PERF_EN is defined.
module wb_retire_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);

    // Count one per retire; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc)
            count <= count + 32'd1;
    end

endmodule

// File: rtl/wb_sequencer.sv
// EXEC/MEM/WB control sequencer with data-memory wait timeout.
// Optional macro WBSEQ_PERF_EN adds the 32-bit 'retired' counter port.
module wb_sequencer #(
    parameter int DM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       ready,
    input  logic [1:0] iclass,
    input  logic       dm_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       memtoreg_sel,
    output logic       reg_write,
    output logic       done,
    output logic       err
`ifdef WBSEQ_PERF_EN
    ,
    output logic [31:0] retired
`endif
);
    import wb_pkg::*;

    localparam int WCW = $clog2(DM_TIMEOUT + 1);

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     cls;
    logic [WCW-1:0] wait_cnt;
    logic [WCW-1:0] wait_inc;

    assign wait_inc = wait_cnt + WCW'(1);

    // State, latched class and MEM wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cls      <= ICLASS_NOP;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start)
                cls <= iclass;
            if (state == ST_EXEC)
                wait_cnt <= '0;
            else if (state == ST_MEM && !dm_ready)
                wait_cnt <= wait_inc;
        end
    end

    // Next-state decode; dm_ready wins over timeout on the last cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = is_mem(cls) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dm_ready)
                    state_nxt = ST_WB;
                else if (wait_inc == WCW'(DM_TIMEOUT))
                    state_nxt = ST_ERR;
            end
            ST_WB:   state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and latched class only.
    always_comb begin
        ready        = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        memtoreg_sel = MEMTOREG_ALU;
        reg_write    = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (state)
            ST_IDLE: ready = 1'b1;
            ST_EXEC: begin
                if (cls == ICLASS_LOAD)
                    memtoreg_sel = MEMTOREG_DM;
            end
            ST_MEM: begin
                mem_read  = (cls == ICLASS_LOAD);
                mem_write = (cls == ICLASS_STORE);
                if (cls == ICLASS_LOAD)
                    memtoreg_sel = MEMTOREG_DM;
            end
            ST_WB: begin
                done      = 1'b1;
                reg_write = writes_reg(cls);
                if (cls == ICLASS_LOAD)
                    memtoreg_sel = MEMTOREG_DM;
            end
            ST_ERR:  err = 1'b1;
            default: ready = 1'b0;
        endcase
    end

`ifdef WBSEQ_PERF_EN
    wb_retire_counter u_retire (
        .clk   (clk),
        .reset (reset),
        .inc   (done),
        .count (retired)
    );
`endif

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer (DM_TIMEOUT=4).
// outs = {ready, mem_read, mem_write, memtoreg_sel, reg_write, done, err}
module tb_wb_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       ready;
    logic [1:0] iclass;
    logic       dm_ready;
    logic       mem_read;
    logic       mem_write;
    logic       memtoreg_sel;
    logic       reg_write;
    logic       done;
    logic       err;
`ifdef WBSEQ_PERF_EN
    logic [31:0] retired;
`endif

    logic [6:0] outs;
    int checks;
    int errors;

    localparam logic [6:0] O_IDLE   = 7'b1001000;
    localparam logic [6:0] O_EXEC_A = 7'b0001000;
    localparam logic [6:0] O_EXEC_L = 7'b0000000;
    localparam logic [6:0] O_WB_R   = 7'b0001110;
    localparam logic [6:0] O_WB_L   = 7'b0000110;
    localparam logic [6:0] O_WB_X   = 7'b0001010;
    localparam logic [6:0] O_MEM_L  = 7'b0100000;
    localparam logic [6:0] O_MEM_S  = 7'b0011000;
    localparam logic [6:0] O_ERR    = 7'b0001001;

    assign outs = {ready, mem_read, mem_write, memtoreg_sel,
                   reg_write, done, err};

    wb_sequencer #(.DM_TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ready        (ready),
        .iclass       (iclass),
        .dm_ready     (dm_ready),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .memtoreg_sel (memtoreg_sel),
        .reg_write    (reg_write),
        .done         (done),
        .err          (err)
`ifdef WBSEQ_PERF_EN
        ,
        .retired      (retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL reset_outs got %b want %b", outs, O_IDLE);
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL reset_idle got %b want %b", outs, O_IDLE);
        end
    endtask

    task automatic test_rtype();
        logic [6:0] ex [1:3];
        ex = '{O_EXEC_A, O_WB_R, O_IDLE};
        start = 1'b1; iclass = 2'b00; dm_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            start = 1'b0;
            checks++;
            if (outs !== ex[i]) begin
                errors++;
                $display("FAIL rtype_c%0d got %b want %b", i, outs, ex[i]);
            end
        end
        dm_ready = 1'b0;
    endtask

    task automatic test_nop();
        logic [6:0] ex [1:3];
        ex = '{O_EXEC_A, O_WB_X, O_IDLE};
        start = 1'b1; iclass = 2'b11;
        for (int i = 1; i <= 3; i++) begin
            step();
            start = 1'b0;
            checks++;
            if (outs !== ex[i]) begin
                errors++;
                $display("FAIL nop_c%0d got %b want %b", i, outs, ex[i]);
            end
        end
    endtask

    task automatic test_load_wait();
        logic [6:0] ex [1:7];
        logic       dr [1:7];
        ex = '{O_EXEC_L, O_MEM_L, O_MEM_L, O_MEM_L, O_MEM_L,
               O_WB_L, O_IDLE};
        dr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        start = 1'b1; iclass = 2'b01; dm_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            start = 1'b0;
            dm_ready = dr[i];
            checks++;
            if (outs !== ex[i]) begin
                errors++;
                $display("FAIL load_wait_c%0d got %b want %b",
                         i, outs, ex[i]);
            end
        end
    endtask

    task automatic test_store();
        logic [6:0] ex [1:4];
        ex = '{O_EXEC_A, O_MEM_S, O_WB_X, O_IDLE};
        start = 1'b1; iclass = 2'b10; dm_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            start = 1'b0;
            checks++;
            if (outs !== ex[i]) begin
                errors++;
                $display("FAIL store_c%0d got %b want %b", i, outs, ex[i]);
            end
        end
        dm_ready = 1'b0;
    endtask

    task automatic test_timeout();
        logic [6:0] ex [1:8];
        ex = '{O_EXEC_L, O_MEM_L, O_MEM_L, O_MEM_L, O_MEM_L,
               O_ERR, O_ERR, O_ERR};
        start = 1'b1; iclass = 2'b01; dm_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 1) start = 1'b0;
            if (i >= 6) begin
                start = 1'b1;
                dm_ready = 1'b1;
            end
            checks++;
            if (outs !== ex[i]) begin
                errors++;
                $display("FAIL timeout_c%0d got %b want %b",
                         i, outs, ex[i]);
            end
        end
        start = 1'b0; dm_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL timeout_reset got %b want %b", outs, O_IDLE);
        end
        step();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL timeout_idle got %b want %b", outs, O_IDLE);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] ex [1:3];
        ex = '{O_EXEC_A, O_MEM_S, O_MEM_S};
        start = 1'b1; iclass = 2'b10; dm_ready = 1'b0;
        step();
        iclass = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (outs !== ex[i]) begin
                errors++;
                $display("FAIL resetmid_c%0d got %b want %b",
                         i, outs, ex[i]);
            end
            if (i < 3) step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL resetmid_abort got %b want %b", outs, O_IDLE);
        end
        step();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL resetmid_idle got %b want %b", outs, O_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ex [1:9];
        ex = '{O_EXEC_A, O_WB_R, O_IDLE, O_EXEC_A, O_WB_R, O_IDLE,
               O_EXEC_A, O_WB_R, O_IDLE};
        start = 1'b1; iclass = 2'b00;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 7) start = 1'b0;
            checks++;
            if (outs !== ex[i]) begin
                errors++;
                $display("FAIL b2b_c%0d got %b want %b", i, outs, ex[i]);
            end
        end
    endtask

`ifdef WBSEQ_PERF_EN
    task automatic test_perf();
        logic [1:0] cl [0:4];
        cl = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset got %0d want 0", retired);
        end
        dm_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            start = 1'b1; iclass = cl[k];
            step();
            start = 1'b0;
            for (int j = 0; j < 4; j++) step();
        end
        checks++;
        if (retired !== 32'd5) begin
            errors++;
            $display("FAIL perf_count got %0d want 5", retired);
        end
        dut.u_retire.count = 32'hFFFF_FFFF;
        start = 1'b1; iclass = 2'b00;
        step();
        start = 1'b0;
        for (int j = 0; j < 3; j++) step();
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL perf_wrap got %0d want 0", retired);
        end
        dm_ready = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        start = 1'b0;
        iclass = 2'b00;
        dm_ready = 1'b0;
        test_reset();
        test_rtype();
        test_nop();
        test_load_wait();
        test_store();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
`ifdef WBSEQ_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
